// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - fetch-stage bundle: instruction-memory port, redirect, decode handshake.
// id_adel exists only when IF_ADDR_EXC_EN is defined.
interface inst_fetch_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
`ifdef IF_ADDR_EXC_EN
  logic        id_adel;
`endif

  modport master (
    output inst_req, inst_addr, id_valid, id_instr, id_pc,
    input  inst_addr_ok, inst_data_ok, inst_rdata, redirect_valid, redirect_pc, id_ready
`ifdef IF_ADDR_EXC_EN
    , output id_adel
`endif
  );

  modport slave (
    input  inst_req, inst_addr, id_valid, id_instr, id_pc,
    output inst_addr_ok, inst_data_ok, inst_rdata, redirect_valid, redirect_pc, id_ready
`ifdef IF_ADDR_EXC_EN
    , input id_adel
`endif
  );
endinterface

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - fetch stage: PC, single-outstanding imem requests, one-entry decode slot.
// IF_ADDR_EXC_EN: misaligned PC produces a held address-error entry instead of a fetch.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input logic          clk,
  input logic          rst,
  inst_fetch_if.master fetch_if
);

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic        held_fault;
  logic        misaligned;
  logic        slot_free;
  logic        issue_ok;
  logic        accept;

`ifdef IF_ADDR_EXC_EN
  logic        adel_q, adel_d;
  assign held_fault       = adel_q;
  assign misaligned       = pc_q[1:0] != 2'b00;
  assign fetch_if.id_adel = adel_q;
`else
  assign held_fault = 1'b0;
  assign misaligned = 1'b0;
`endif

  function automatic logic [31:0] align_pc(input logic [31:0] a);
`ifdef IF_ADDR_EXC_EN
    return a;
`else
    return a & ~32'h3;
`endif
  endfunction

  // A faulting entry is never consumed by id_ready; only a redirect clears it.
  assign slot_free = !id_valid_q || (fetch_if.id_ready && !held_fault);
  assign issue_ok  = !rst && (state_q == IDLE) && slot_free && !fetch_if.redirect_valid;
  assign accept    = fetch_if.inst_req && fetch_if.inst_addr_ok;

  assign fetch_if.inst_req  = issue_ok && !misaligned;
  assign fetch_if.inst_addr = pc_q;
  assign fetch_if.id_valid  = id_valid_q;
  assign fetch_if.id_instr  = id_instr_q;
  assign fetch_if.id_pc     = id_pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    id_valid_d = id_valid_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
`ifdef IF_ADDR_EXC_EN
    adel_d     = adel_q;
`endif

    if (id_valid_q && fetch_if.id_ready && !held_fault) begin
      id_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = WAIT;
        end
`ifdef IF_ADDR_EXC_EN
        if (issue_ok && misaligned) begin
          id_valid_d = 1'b1;
          id_instr_d = 32'h0;
          id_pc_d    = pc_q;
          adel_d     = 1'b1;
        end
`endif
      end
      WAIT: begin
        if (fetch_if.inst_data_ok) begin
          id_valid_d = 1'b1;
          id_instr_d = fetch_if.inst_rdata;
          id_pc_d    = req_pc_q;
`ifdef IF_ADDR_EXC_EN
          adel_d     = 1'b0;
`endif
          state_d    = IDLE;
        end
      end
      DISCARD: begin
        if (fetch_if.inst_data_ok) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Redirect overrides everything above; an outstanding response must still be drained.
    if (fetch_if.redirect_valid) begin
      pc_d       = align_pc(fetch_if.redirect_pc);
      id_valid_d = 1'b0;
      id_instr_d = id_instr_q;
      id_pc_d    = id_pc_q;
`ifdef IF_ADDR_EXC_EN
      adel_d     = 1'b0;
`endif
      if (state_q == IDLE) begin
        state_d = accept ? DISCARD : IDLE;
      end else begin
        state_d = fetch_if.inst_data_ok ? IDLE : DISCARD;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= align_pc(RESET_PC);
      req_pc_q   <= 32'h0;
      id_valid_q <= 1'b0;
      id_instr_q <= 32'h0;
      id_pc_q    <= 32'h0;
`ifdef IF_ADDR_EXC_EN
      adel_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
`ifdef IF_ADDR_EXC_EN
      adel_q     <= adel_d;
`endif
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - scoreboard bench for inst_fetch with a behavioural instruction memory.
module tb_inst_fetch;
  localparam logic [31:0] RPC = 32'hBFC0_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_fetch_if bus();
  inst_fetch #(.RESET_PC(RPC)) dut (.clk(clk), .rst(rst), .fetch_if(bus));

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic [31:0] exp_addr[$];
  logic [63:0] exp_id[$];
  int hs_cyc[$];
  bit mon_en = 1'b1;

  int acc_count = 0;
  int acc_limit = 0;
  int mem_delay = 1;
  bit mem_pend = 1'b0;
  int mem_cnt = 0;
  logic [31:0] mem_paddr = 32'h0;
  logic mem_acc;
  logic [31:0] mem_a;

  assign bus.inst_addr_ok = bus.inst_req && (acc_count < acc_limit);

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory: samples acceptance mid-cycle, answers mem_delay cycles after it.
  initial begin
    bus.inst_data_ok = 1'b0;
    bus.inst_rdata   = 32'h0;
    forever begin
      @(negedge clk);
      mem_acc = bus.inst_req && bus.inst_addr_ok;
      mem_a   = bus.inst_addr;
      @(posedge clk);
      #1;
      bus.inst_data_ok = 1'b0;
      if (mem_acc) begin
        mem_pend  = 1'b1;
        mem_paddr = mem_a;
        mem_cnt   = mem_delay;
        acc_count++;
      end
      if (mem_pend) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          bus.inst_data_ok = 1'b1;
          bus.inst_rdata   = instr_of(mem_paddr);
          mem_pend         = 1'b0;
        end
      end
    end
  end

  // Monitor: requests and decode handshakes checked against the expectation queues.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (bus.inst_req && bus.inst_addr_ok) begin
        if (exp_addr.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL inst_addr: unexpected request addr %h", bus.inst_addr);
        end else begin
          chk("inst_addr", bus.inst_addr, exp_addr.pop_front());
        end
      end
      if (mon_en && bus.id_valid && bus.id_ready) begin
        hs_cyc.push_back(cyc);
        if (exp_id.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL id_out: unexpected entry pc %h instr %h", bus.id_pc, bus.id_instr);
        end else begin
          e = exp_id.pop_front();
          chk("id_pc", bus.id_pc, e[63:32]);
          chk("id_instr", bus.id_instr, e[31:0]);
`ifdef IF_ADDR_EXC_EN
          chk("id_adel_normal", bus.id_adel, 1'b0);
`endif
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_fetch(input logic [31:0] a);
    exp_addr.push_back(a);
    exp_id.push_back({a, instr_of(a)});
  endtask

  task automatic allow(input int n);
    acc_limit = acc_count + n;
  endtask

  task automatic reset_on();
    step();
    rst = 1'b1;
    #1;
    chk("rst_inst_req", bus.inst_req, 1'b0);
    chk("rst_id_valid", bus.id_valid, 1'b0);
    chk("rst_inst_addr", bus.inst_addr, RPC);
    chk("rst_id_pc", bus.id_pc, 32'h0);
    chk("rst_id_instr", bus.id_instr, 32'h0);
    step();
  endtask

  task automatic reset_off();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_acc(input int n);
    int k = 0;
    while (acc_count < n && k < 50) begin step(); k++; end
    chk("wait_accept", 32'(acc_count >= n), 32'd1);
  endtask

  task automatic wait_valid();
    int k = 0;
    while (!bus.id_valid && k < 30) begin step(); k++; end
    chk("wait_id_valid", bus.id_valid, 1'b1);
  endtask

  task automatic drain(input string name);
    int k = 0;
    while ((exp_addr.size() + exp_id.size()) != 0 && k < 60) begin step(); k++; end
    step();
    chk(name, 32'(exp_addr.size() + exp_id.size()), 32'd0);
  endtask

  initial begin
    int base;
    bus.id_ready       = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;

    // Sequential fetch, zero-wait memory, one entry per two cycles.
    reset_on();
    hs_cyc.delete();
    expect_fetch(RPC);
    expect_fetch(RPC + 32'd4);
    expect_fetch(RPC + 32'd8);
    allow(3);
    reset_off();
    drain("drain_seq");
    if (hs_cyc.size() >= 3) begin
      chk("spacing_1", 32'(hs_cyc[1] - hs_cyc[0]), 32'd2);
      chk("spacing_2", 32'(hs_cyc[2] - hs_cyc[1]), 32'd2);
    end else begin
      chk("handshake_count", 32'(hs_cyc.size()), 32'd3);
    end

    // Decode stall holds the entry and blocks further requests.
    bus.id_ready = 1'b0;
    reset_on();
    expect_fetch(RPC);
    expect_fetch(RPC + 32'd4);
    allow(2);
    reset_off();
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_inst_req", bus.inst_req, 1'b0);
      chk("stall_id_pc", bus.id_pc, RPC);
      chk("stall_id_instr", bus.id_instr, instr_of(RPC));
    end
    bus.id_ready = 1'b1;
    drain("drain_stall");

    // Redirect while waiting; stale response arrives three cycles later.
    reset_on();
    exp_addr.push_back(RPC);
    mem_delay = 3;
    allow(1);
    reset_off();
    base = acc_count;
    wait_acc(base + 1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_1000;
    step();
    bus.redirect_valid = 1'b0;
    chk("discard_inst_req", bus.inst_req, 1'b0);
    mem_delay = 1;
    expect_fetch(32'h0000_1000);
    allow(1);
    drain("drain_redir_wait");

    // Redirect in the cycle a request would otherwise be accepted.
    reset_on();
    expect_fetch(32'h0000_2000);
    allow(1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_2000;
    reset_off();
    chk("redir_suppress_req", bus.inst_req, 1'b0);
    step();
    bus.redirect_valid = 1'b0;
    drain("drain_redir_addr_ok");

    // Redirect coincident with data_ok while waiting.
    reset_on();
    exp_addr.push_back(RPC);
    mem_delay = 2;
    allow(1);
    reset_off();
    base = acc_count;
    wait_acc(base + 1);
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_3000;
    step();
    bus.redirect_valid = 1'b0;
    chk("redir_data_id_valid", bus.id_valid, 1'b0);
    mem_delay = 1;
    expect_fetch(32'h0000_3000);
    allow(1);
    drain("drain_redir_data");

    // Reset mid-wait; stray response after release must be ignored.
    reset_on();
    exp_addr.push_back(RPC);
    mem_delay = 4;
    allow(1);
    reset_off();
    base = acc_count;
    wait_acc(base + 1);
    rst = 1'b1;
    #1;
    chk("midrst_inst_req", bus.inst_req, 1'b0);
    chk("midrst_id_valid", bus.id_valid, 1'b0);
    chk("midrst_inst_addr", bus.inst_addr, RPC);
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("stray_id_valid", bus.id_valid, 1'b0);
    mem_delay = 1;
    expect_fetch(RPC);
    allow(1);
    drain("drain_midrst");

    // Redirect to a misaligned target.
    reset_on();
    reset_off();
`ifdef IF_ADDR_EXC_EN
    mon_en = 1'b0;
    base = acc_count;
    allow(1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_1002;
    step();
    bus.redirect_valid = 1'b0;
    step();
    chk("adel_id_valid", bus.id_valid, 1'b1);
    chk("adel_flag", bus.id_adel, 1'b1);
    chk("adel_id_pc", bus.id_pc, 32'h0000_1002);
    chk("adel_id_instr", bus.id_instr, 32'h0);
    for (int i = 0; i < 3; i++) step();
    chk("adel_held", bus.id_valid, 1'b1);
    chk("adel_no_req", bus.inst_req, 1'b0);
    chk("adel_no_accept", 32'(acc_count), 32'(base));
    expect_fetch(32'h0000_1000);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_1000;
    step();
    bus.redirect_valid = 1'b0;
    mon_en = 1'b1;
    drain("drain_adel");
`else
    expect_fetch(32'h0000_1000);
    allow(1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_1002;
    step();
    bus.redirect_valid = 1'b0;
    drain("drain_align");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", n_err);
    $fatal(1, "watchdog expired");
  end
endmodule
